keypad_scan: RTL and testbench

- 4x4 matrix keypad scanner; the input-side counterpart of the multiplexed 7-segment scan driver.
- Drives one keypad row low at a time and samples the active-low columns, the mirror image of a digit-select scan.
- Debounces across whole scan frames and reports one code per confirmed press.
- Sits at the board boundary; its key_code/key_valid feed the same control logic that supplies data to the display driver.

---
 rtl/keypad_scan.sv | 197 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner.
// Row-at-a-time scan, frame-level debounce, one code per press.
module keypad_scan #(
    parameter int CLK_DIV  = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] ROW,
    input  logic [3:0] COL,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE);
    localparam logic [CW-1:0] DB_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIRM,
        S_HELD,
        S_RELEASE
    } state_t;

    logic [3:0]    col_meta_q, col_meta_d;
    logic [3:0]    col_sync_q, col_sync_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_q, row_d;
    logic          found_q, found_d;
    logic [3:0]    fcode_q, fcode_d;
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic          tick;
    logic          frame_end;
    logic [3:0]    col_hit;
    logic [1:0]    low_col;
    logic          row_found;
    logic [3:0]    row_code;
    logic          frame_found;
    logic [3:0]    frame_code;

    // Column synchronizer, tick divider and row rotation.
    always_comb begin
        col_meta_d = COL;
        col_sync_d = col_meta_q;
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        row_idx_d  = tick ? row_idx_q + 2'd1 : row_idx_q;
        row_d      = ~(4'b0001 << row_idx_d);
        frame_end  = tick && (row_idx_q == 2'd3);
    end

    // Per-row sample and frame accumulation; earlier rows keep priority.
    always_comb begin
        col_hit   = ~col_sync_q;
        row_found = |col_hit;
        casez (col_hit)
            4'b???1: low_col = 2'd0;
            4'b??10: low_col = 2'd1;
            4'b?100: low_col = 2'd2;
            4'b1000: low_col = 2'd3;
            default: low_col = 2'd0;
        endcase
        row_code    = {row_idx_q, low_col};
        frame_found = found_q | row_found;
        frame_code  = found_q ? fcode_q : row_code;
        found_d     = found_q;
        fcode_d     = fcode_q;
        if (tick) begin
            if (frame_end) begin
                found_d = 1'b0;
                fcode_d = 4'd0;
            end else begin
                found_d = frame_found;
                fcode_d = frame_code;
            end
        end
    end

    // Debounce FSM, advanced once per completed frame.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (frame_end) begin
            unique case (state_q)
                S_IDLE: begin
                    if (frame_found) begin
                        cand_d = frame_code;
                        if (DEBOUNCE == 1) begin
                            cnt_d       = DB_MAX;
                            key_code_d  = frame_code;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            state_d     = S_HELD;
                        end else begin
                            cnt_d   = DB_ONE;
                            state_d = S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (!frame_found) begin
                        state_d = S_IDLE;
                    end else if (frame_code != cand_q) begin
                        cand_d = frame_code;
                        cnt_d  = DB_ONE;
                    end else if (cnt_q == DB_LAST) begin
                        cnt_d       = DB_MAX;
                        key_code_d  = cand_q;
                        key_valid_d = 1'b1;
                        key_down_d  = 1'b1;
                        state_d     = S_HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!frame_found) begin
                        if (DEBOUNCE == 1) begin
                            key_down_d = 1'b0;
                            state_d    = S_IDLE;
                        end else begin
                            cnt_d   = DB_ONE;
                            state_d = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (frame_found) begin
                        state_d = S_HELD;
                    end else if (cnt_q == DB_LAST) begin
                        cnt_d      = DB_MAX;
                        key_down_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_q  <= 4'hF;
            col_sync_q  <= 4'hF;
            tick_cnt_q  <= '0;
            row_idx_q   <= 2'd0;
            row_q       <= 4'b1110;
            found_q     <= 1'b0;
            fcode_q     <= 4'd0;
            state_q     <= S_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            col_meta_q  <= col_meta_d;
            col_sync_q  <= col_sync_d;
            tick_cnt_q  <= tick_cnt_d;
            row_idx_q   <= row_idx_d;
            row_q       <= row_d;
            found_q     <= found_d;
            fcode_q     <= fcode_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign ROW       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: frame-driven keypad stimulus with a
// history-based press/release reference model.
module tb_keypad_scan;

    localparam int CDIV = 4;
    localparam int DEB  = 3;
    localparam int FRAME = 4 * CDIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: run of identical frame values.
    logic       m_down;
    logic [3:0] m_code;
    int         m_last;
    int         m_run;

    keypad_scan #(
        .CLK_DIV (CDIV),
        .DEBOUNCE(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ROW      (ROW),
        .COL      (COL),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Passive matrix: a column reads low when a pressed key's row is driven.
    always_comb begin
        COL = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[r*4+c] && (ROW[r] == 1'b0)) COL[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_down = 1'b0;
        m_code = 4'd0;
        m_last = -1;
        m_run  = 0;
    endtask

    // Entered at a negedge; leaves at the negedge after the reset edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_row", ROW, 4'b1110);
        chk("rst_code", key_code, 4'd0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_down", key_down, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Hold one key set for a whole frame and check every cycle of it.
    task automatic run_frame(input logic [15:0] keys);
        int         v;
        logic       exp_p;
        logic       dn_b;
        logic [3:0] cd_b;
        logic [3:0] er;
        pressed = keys;
        dn_b = m_down;
        cd_b = m_code;
        v = 16;
        for (int k = 15; k >= 0; k--) if (keys[k]) v = k;
        if (v == m_last) begin
            m_run++;
        end else begin
            m_run  = 1;
            m_last = v;
        end
        exp_p = 1'b0;
        if (!m_down && v != 16 && m_run == DEB) begin
            exp_p  = 1'b1;
            m_down = 1'b1;
            m_code = 4'(v);
        end else if (m_down && v == 16 && m_run == DEB) begin
            m_down = 1'b0;
        end
        for (int j = 1; j <= FRAME; j++) begin
            @(posedge clk);
            #1;
            er = 4'b1111;
            er[(j / CDIV) % 4] = 1'b0;
            chk("row", ROW, er);
            if (j < FRAME) begin
                chk("valid_mid", key_valid, 1'b0);
                chk("down_mid", key_down, dn_b);
                chk("code_mid", key_code, cd_b);
            end else begin
                chk("valid_end", key_valid, exp_p);
                chk("down_end", key_down, m_down);
                chk("code_end", key_code, m_code);
            end
        end
        @(negedge clk);
    endtask

    task automatic frames(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) run_frame(keys);
    endtask

    initial begin
        logic [15:0] ks;
        int          pick;
        pressed = 16'h0;
        model_reset();
        do_reset();

        frames(16'h0, 2);

        frames(16'h1 << 6, 4);
        frames(16'h0, 4);

        run_frame(16'h1 << 9);
        run_frame(16'h0);
        run_frame(16'h1 << 9);
        run_frame(16'h0);
        frames(16'h1 << 9, 4);
        frames(16'h0, 3);

        frames((16'h1 << 5) | (16'h1 << 10), 4);
        frames(16'h1 << 10, 2);
        frames(16'h0, 3);

        frames(16'h1 << 15, 10);
        run_frame(16'h0);
        frames(16'h1 << 15, 10);
        frames(16'h0, 3);

        frames(16'h1 << 3, 2);
        do_reset();
        frames(16'h1 << 3, 3);
        frames(16'h0, 3);

        ks = 16'h0;
        for (int b = 0; b < 14; b++) begin
            pick = $urandom_range(0, 3);
            if (pick == 0) begin
                ks = 16'h0;
            end else if (pick == 2) begin
                ks = 16'h0;
                ks[$urandom_range(0, 15)] = 1'b1;
            end else if (pick == 3) begin
                ks = 16'h0;
                ks[$urandom_range(0, 15)] = 1'b1;
                ks[$urandom_range(0, 15)] = 1'b1;
            end
            frames(ks, $urandom_range(1, 5));
        end
        frames(16'h0, 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
